// File: rtl/mir_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mir_decoder
// Purpose  : Registers each microinstruction word from the control unit and
//            decodes it into datapath strobes. Runs the memory request /
//            acknowledge handshake and holds the control unit (cu_hold) while
//            a memory access is outstanding, after the program has ended, or
//            after an error.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            mir [MIR_W-1:0]   - control word (changes on falling edge)
//            mem_ack           - memory access complete
//            mem_rd / mem_wr   - level memory requests, held until ack
//            reg_we [NREG-1:0] - register write enables
//            bus_sel, alu_op   - bus source select, ALU operation
//            flag_ctl, pc_inc  - flag update control, PC increment strobe
//            cu_hold, halted   - control unit stall, end of program
//            mem_err           - sticky timeout / rd+wr conflict
//            illegal_sel       - sticky illegal bus source code seen
//            uinstr_count      - completed microinstructions, saturating
// Revision : 1.0 - initial release
// ============================================================================
module mir_decoder #(
    parameter int MIR_W   = 36,
    parameter int NREG    = 9,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MIR_W-1:0] mir,
    input  logic             mem_ack,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [NREG-1:0]  reg_we,
    output logic [3:0]       bus_sel,
    output logic [3:0]       alu_op,
    output logic [1:0]       flag_ctl,
    output logic             pc_inc,
    output logic             cu_hold,
    output logic             halted,
    output logic             mem_err,
    output logic             illegal_sel,
    output logic [15:0]      uinstr_count
);

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_ST_HALT     = 2'd2;
    localparam logic [1:0] c_ST_ERR      = 2'd3;

    localparam int          c_WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [3:0]  c_BUS_MAX   = 4'd10;
    localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

    // Field decode; only these bits of the word can influence the outputs
    logic            w_req_rd;
    logic            w_req_wr;
    logic            w_end;
    logic            w_pc;
    logic [NREG-1:0] w_we;
    logic [3:0]      w_alu;
    logic [3:0]      w_bus_raw;
    logic [1:0]      w_flag;
    logic            w_bus_bad;
    logic [3:0]      w_bus;
    logic            w_unused;

    assign w_we      = mir[18 +: NREG];
    assign w_req_wr  = mir[13];
    assign w_pc      = mir[12];
    assign w_req_rd  = mir[11];
    assign w_alu     = mir[10:7];
    assign w_bus_raw = mir[6:3];
    assign w_flag    = mir[2:1];
    assign w_end     = mir[0];
    assign w_bus_bad = (w_bus_raw > c_BUS_MAX);
    assign w_bus     = w_bus_bad ? 4'd0 : w_bus_raw;
    assign w_unused  = ^{mir[MIR_W-1:27], mir[17:14]};

    // State and registered outputs
    logic [1:0]          r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [NREG-1:0]     r_lat_we;
    logic                r_lat_pc;
    logic                r_lat_end;
    logic                r_mem_rd, r_mem_wr;
    logic [NREG-1:0]     r_reg_we;
    logic [3:0]          r_bus_sel, r_alu_op;
    logic [1:0]          r_flag_ctl;
    logic                r_pc_inc, r_cu_hold, r_halted, r_mem_err, r_illegal;
    logic [15:0]         r_count;

    // Next-state values
    logic [1:0]          w_state_n;
    logic [c_WAIT_W-1:0] w_wait_n;
    logic [NREG-1:0]     w_lat_we_n;
    logic                w_lat_pc_n, w_lat_end_n;
    logic                w_mem_rd_n, w_mem_wr_n;
    logic [NREG-1:0]     w_reg_we_n;
    logic [3:0]          w_bus_sel_n, w_alu_op_n;
    logic [1:0]          w_flag_ctl_n;
    logic                w_pc_inc_n, w_cu_hold_n, w_halted_n, w_mem_err_n, w_illegal_n;
    logic [15:0]         w_count_n;
    logic [15:0]         w_count_inc;

    assign w_count_inc = (r_count == c_COUNT_MAX) ? r_count : r_count + 16'd1;

    always_comb begin
        // Strobes default to idle; sticky and latched state default to hold
        w_state_n    = r_state;
        w_wait_n     = r_wait_cnt;
        w_lat_we_n   = r_lat_we;
        w_lat_pc_n   = r_lat_pc;
        w_lat_end_n  = r_lat_end;
        w_mem_rd_n   = 1'b0;
        w_mem_wr_n   = 1'b0;
        w_reg_we_n   = '0;
        w_bus_sel_n  = 4'd0;
        w_alu_op_n   = 4'd0;
        w_flag_ctl_n = 2'd0;
        w_pc_inc_n   = 1'b0;
        w_cu_hold_n  = r_cu_hold;
        w_halted_n   = r_halted;
        w_mem_err_n  = r_mem_err;
        w_illegal_n  = r_illegal;
        w_count_n    = r_count;

        case (r_state)
            c_ST_RUN: begin
                w_illegal_n = r_illegal | w_bus_bad;
                if (w_req_rd && w_req_wr) begin
                    // Conflicting request: nothing is issued, the word is dropped
                    w_state_n   = c_ST_ERR;
                    w_mem_err_n = 1'b1;
                    w_cu_hold_n = 1'b1;
                end else if (w_req_rd || w_req_wr) begin
                    // Write enables and PC increment wait for the ack
                    w_state_n    = c_ST_MEM_WAIT;
                    w_mem_rd_n   = w_req_rd;
                    w_mem_wr_n   = w_req_wr;
                    w_cu_hold_n  = 1'b1;
                    w_bus_sel_n  = w_bus;
                    w_alu_op_n   = w_alu;
                    w_flag_ctl_n = w_flag;
                    w_lat_we_n   = w_we;
                    w_lat_pc_n   = w_pc;
                    w_lat_end_n  = w_end;
                    w_wait_n     = '0;
                end else begin
                    w_reg_we_n   = w_we;
                    w_pc_inc_n   = w_pc;
                    w_bus_sel_n  = w_bus;
                    w_alu_op_n   = w_alu;
                    w_flag_ctl_n = w_flag;
                    w_count_n    = w_count_inc;
                    if (w_end) begin
                        w_state_n   = c_ST_HALT;
                        w_cu_hold_n = 1'b1;
                        w_halted_n  = 1'b1;
                    end
                end
            end

            c_ST_MEM_WAIT: begin
                // Bus/ALU/flag selection stays on through the completing write cycle
                w_bus_sel_n  = r_bus_sel;
                w_alu_op_n   = r_alu_op;
                w_flag_ctl_n = r_flag_ctl;
                if (mem_ack) begin
                    w_reg_we_n = r_lat_we;
                    w_pc_inc_n = r_lat_pc;
                    w_count_n  = w_count_inc;
                    if (r_lat_end) begin
                        w_state_n   = c_ST_HALT;
                        w_cu_hold_n = 1'b1;
                        w_halted_n  = 1'b1;
                    end else begin
                        w_state_n   = c_ST_RUN;
                        w_cu_hold_n = 1'b0;
                    end
                end else if (r_wait_cnt == c_WAIT_W'(TIMEOUT - 1)) begin
                    w_state_n    = c_ST_ERR;
                    w_mem_err_n  = 1'b1;
                    w_cu_hold_n  = 1'b1;
                    w_bus_sel_n  = 4'd0;
                    w_alu_op_n   = 4'd0;
                    w_flag_ctl_n = 2'd0;
                end else begin
                    w_mem_rd_n = r_mem_rd;
                    w_mem_wr_n = r_mem_wr;
                    w_wait_n   = r_wait_cnt + c_WAIT_W'(1);
                end
            end

            c_ST_HALT: begin
                w_cu_hold_n = 1'b1;
                w_halted_n  = 1'b1;
            end

            default: begin
                w_cu_hold_n = 1'b1;
                w_mem_err_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_RUN;
            r_wait_cnt <= '0;
            r_lat_we   <= '0;
            r_lat_pc   <= 1'b0;
            r_lat_end  <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_reg_we   <= '0;
            r_bus_sel  <= 4'd0;
            r_alu_op   <= 4'd0;
            r_flag_ctl <= 2'd0;
            r_pc_inc   <= 1'b0;
            r_cu_hold  <= 1'b0;
            r_halted   <= 1'b0;
            r_mem_err  <= 1'b0;
            r_illegal  <= 1'b0;
            r_count    <= 16'd0;
        end else begin
            r_state    <= w_state_n;
            r_wait_cnt <= w_wait_n;
            r_lat_we   <= w_lat_we_n;
            r_lat_pc   <= w_lat_pc_n;
            r_lat_end  <= w_lat_end_n;
            r_mem_rd   <= w_mem_rd_n;
            r_mem_wr   <= w_mem_wr_n;
            r_reg_we   <= w_reg_we_n;
            r_bus_sel  <= w_bus_sel_n;
            r_alu_op   <= w_alu_op_n;
            r_flag_ctl <= w_flag_ctl_n;
            r_pc_inc   <= w_pc_inc_n;
            r_cu_hold  <= w_cu_hold_n;
            r_halted   <= w_halted_n;
            r_mem_err  <= w_mem_err_n;
            r_illegal  <= w_illegal_n;
            r_count    <= w_count_n;
        end
    end

    assign mem_rd       = r_mem_rd;
    assign mem_wr       = r_mem_wr;
    assign reg_we       = r_reg_we;
    assign bus_sel      = r_bus_sel;
    assign alu_op       = r_alu_op;
    assign flag_ctl     = r_flag_ctl;
    assign pc_inc       = r_pc_inc;
    assign cu_hold      = r_cu_hold;
    assign halted       = r_halted;
    assign mem_err      = r_mem_err;
    assign illegal_sel  = r_illegal;
    assign uinstr_count = r_count;

endmodule
`default_nettype wire
